// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// hands {instruction, inst_pc, inst_valid} to decode with stall and redirect/squash.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | request presented at pc, waiting for imem handshake
// WAIT  | request accepted, waiting for response
// HOLD  | instruction presented to decode until it is consumed
// DRAIN | accepted request was squashed by redirect, discard its response
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        fetch_misalign
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

   state_t      state;
   state_t      nxt;
   logic [31:0] pc;

   assign imem_req_addr = pc;

   always_comb begin
      nxt = state;
      if (redirect_valid) begin
         case (state)
            REQ:         nxt = imem_req_ready ? DRAIN : REQ;
            WAIT, DRAIN: nxt = imem_rsp_valid ? REQ : DRAIN;
            default:     nxt = REQ;
         endcase
      end else begin
         case (state)
            IDLE:    nxt = REQ;
            REQ:     if (imem_req_ready) nxt = WAIT;
            WAIT:    if (imem_rsp_valid) nxt = HOLD;
            HOLD:    if (!stall) nxt = REQ;
            DRAIN:   if (imem_rsp_valid) nxt = REQ;
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         instruction    <= NOP;
         inst_pc        <= RESET_PC;
         inst_valid     <= 1'b0;
         fetch_misalign <= 1'b0;
         imem_req_valid <= 1'b0;
      end else begin
         state          <= nxt;
         imem_req_valid <= (nxt == REQ);
         fetch_misalign <= redirect_valid && (|redirect_pc[1:0]);
         // redirect wins over capture, so a response arriving with it is dropped
         if (redirect_valid) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            inst_valid <= 1'b0;
         end else if (state == WAIT && imem_rsp_valid) begin
            instruction <= imem_rsp_data;
            inst_pc     <= pc;
            inst_valid  <= 1'b1;
            pc          <= pc + 32'd4;
         end else if (state == HOLD && !stall) begin
            inst_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_inst_fetch;

   logic        clk;
   logic        rst, ready, rsp_valid, redir, stall;
   logic [31:0] rsp_data, redir_pc;
   logic        req_valid, inst_valid, misalign;
   logic [31:0] req_addr, instruction, inst_pc;

   logic        w_rst, w_ready, w_rsp_valid, w_redir, w_stall;
   logic [31:0] w_rsp_data, w_redir_pc;
   logic        w_req_valid, w_inst_valid, w_misalign;
   logic [31:0] w_req_addr, w_instruction, w_inst_pc;

   int n_chk = 0;
   int n_fail = 0;

   inst_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_req_addr(req_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .redirect_valid(redir), .redirect_pc(redir_pc), .stall(stall),
      .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .fetch_misalign(misalign)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(w_rst),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_req_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(w_redir), .redirect_pc(w_redir_pc), .stall(w_stall),
      .instruction(w_instruction), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid),
      .fetch_misalign(w_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: one request may be outstanding; a redirect marks it squashed.
   bit          m_live = 0;
   bit          m_idle, m_out, m_sq, m_hold, m_iv, m_mis;
   logic [31:0] m_pc, m_instr, m_ipc;

   function automatic bit m_req();
      return !m_idle && !m_out && !m_hold;
   endfunction

   always @(posedge clk) begin
      bit fire, got;
      if (rst) begin
         m_live = 1; m_idle = 1; m_out = 0; m_sq = 0; m_hold = 0;
         m_iv = 0; m_mis = 0; m_pc = 32'h0; m_instr = 32'h13; m_ipc = 32'h0;
      end else if (m_live) begin
         fire  = m_req() && ready;
         got   = m_out && rsp_valid;
         m_mis = 0;
         if (redir) begin
            m_pc = redir_pc & 32'hFFFF_FFFC;
            m_iv = 0; m_mis = (redir_pc % 4) != 0; m_hold = 0; m_idle = 0;
            if (fire) begin m_out = 1; m_sq = 1; end
            else if (got) begin m_out = 0; m_sq = 0; end
            else if (m_out) m_sq = 1;
         end else if (m_idle) begin
            m_idle = 0;
         end else if (fire) begin
            m_out = 1; m_sq = 0;
         end else if (got) begin
            if (!m_sq) begin
               m_instr = rsp_data; m_ipc = m_pc; m_iv = 1; m_hold = 1;
               m_pc = m_pc + 4;
            end
            m_out = 0; m_sq = 0;
         end else if (m_hold && !stall) begin
            m_hold = 0; m_iv = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("req_valid", req_valid, m_req());
         if (m_req()) chk("req_addr", req_addr, m_pc);
         chk("inst_valid", inst_valid, m_iv);
         chk("instruction", instruction, m_instr);
         chk("inst_pc", inst_pc, m_ipc);
         chk("fetch_misalign", misalign, m_mis);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_req(output logic [31:0] a);
      bit seen = 0;
      a = 32'hx;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (req_valid) begin seen = 1; a = req_addr; end
         else cyc(1);
      end
      if (!seen) chk("req_timeout", 32'(req_valid), 32'd1);
   endtask

   task automatic respond(input logic [31:0] d, input int k);
      if (k > 1) cyc(k - 1);
      rsp_valid = 1; rsp_data = d;
      cyc(1);
      rsp_valid = 0; rsp_data = 32'h0;
   endtask

   task automatic fetch(input logic [31:0] d, input int k, output logic [31:0] a);
      wait_req(a);
      cyc(1);
      respond(d, k);
   endtask

   initial begin
      logic [31:0] a;
      rst = 1; ready = 1; rsp_valid = 0; rsp_data = 0; redir = 0; redir_pc = 0; stall = 0;
      w_rst = 1; w_ready = 1; w_rsp_valid = 0; w_rsp_data = 0; w_redir = 0; w_redir_pc = 0;
      w_stall = 0;
      cyc(2);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_instruction", instruction, 32'h0000_0013);
      rst = 0;

      // basic fetch, then stalled hold
      stall = 1;
      fetch(32'h0050_0093, 1, a);
      chk("t1_addr", a, 32'h0);
      chk("t1_instr", instruction, 32'h0050_0093);
      chk("t1_pc", inst_pc, 32'h0);
      chk("t1_valid", inst_valid, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("t2_instr", instruction, 32'h0050_0093);
         chk("t2_req", req_valid, 0);
      end
      stall = 0;
      cyc(1);
      chk("t2_valid", inst_valid, 0);
      chk("t2_addr", req_addr, 32'h4);

      // redirect while waiting, late response drained
      cyc(1);
      redir = 1; redir_pc = 32'h100;
      cyc(1);
      redir = 0;
      chk("t3_valid", inst_valid, 0);
      cyc(1);
      respond(32'hDEAD_BEEF, 1);
      chk("t3_instr", instruction, 32'h0050_0093);
      chk("t3_addr", req_addr, 32'h100);

      // misaligned redirect from HOLD
      fetch(32'h0010_0113, 1, a);
      chk("t4_fetch_addr", a, 32'h100);
      redir = 1; redir_pc = 32'h102;
      cyc(1);
      redir = 0;
      chk("t4_mis", misalign, 1);
      chk("t4_addr", req_addr, 32'h100);
      cyc(1);
      chk("t4_mis_end", misalign, 0);
      respond(32'h0020_0193, 2);
      chk("t4_pc", inst_pc, 32'h100);

      // redirect in REQ without ready, then wrap at top of address space
      ready = 0;
      cyc(1);
      redir = 1; redir_pc = 32'hFFFF_FFFC;
      cyc(1);
      redir = 0; ready = 1;
      chk("t5_addr", req_addr, 32'hFFFF_FFFC);
      fetch(32'h0030_0213, 1, a);
      chk("t5_pc", inst_pc, 32'hFFFF_FFFC);
      cyc(1);
      chk("t5_wrap", req_addr, 32'h0);

      // redirect together with response in WAIT
      cyc(1);
      redir = 1; redir_pc = 32'h200; rsp_valid = 1; rsp_data = 32'h0000_0BAD;
      cyc(1);
      redir = 0; rsp_valid = 0;
      chk("t5b_addr", req_addr, 32'h200);
      chk("t5b_valid", inst_valid, 0);

      // reset during WAIT, stale response afterwards
      cyc(1);
      rst = 1; ready = 0;
      cyc(1);
      rst = 0; rsp_valid = 1; rsp_data = 32'h0000_CAFE;
      cyc(2);
      rsp_valid = 0;
      chk("t6_valid", inst_valid, 0);
      chk("t6_req", req_valid, 1);
      chk("t6_addr", req_addr, 32'h0);
      chk("t6_instr", instruction, 32'h0000_0013);
      ready = 1;
      fetch(32'h0040_0293, 3, a);
      chk("t6_fetch_addr", a, 32'h0);
      chk("t6_fetch_instr", instruction, 32'h0040_0293);

      // non-zero RESET_PC instance
      w_rst = 0;
      cyc(1);
      chk("w_req", w_req_valid, 1);
      chk("w_addr0", w_req_addr, 32'hFFFF_FFFC);
      cyc(1);
      w_rsp_valid = 1; w_rsp_data = 32'h0060_0313;
      cyc(1);
      w_rsp_valid = 0;
      chk("w_pc", w_inst_pc, 32'hFFFF_FFFC);
      chk("w_valid", w_inst_valid, 1);
      cyc(1);
      chk("w_addr1", w_req_addr, 32'h0);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
